// File: rtl/vga_fb_scan.sv
// vga_fb_scan: parametrised VGA timing generator and framebuffer reader.
// Scans the raster and fetches RGB565 pixels from a BRAM read port, or it
// produces built-in test patterns instead. All logic runs in the pixel clock
// domain. Sync and blanking are delayed to line up with the BRAM read latency.
//
// Read port timing: mem_addr/mem_rd are registered one cycle after the
// counter state they describe. mem_data must be valid exactly RD_LAT cycles
// later. There is no back-pressure: the BRAM is assumed to serve every request.
module vga_fb_scan #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int ADDR_W      = 19,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [11:0]       bg_color,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic              hs,
  output logic              vs,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 5 bits wide so the grid pattern can test bits [4:0].
  localparam int HW       = ($clog2(H_TOTAL) > 5) ? $clog2(H_TOTAL) : 5;
  localparam int VW       = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int LINE_W   = H_ACTIVE >> SCALE_SHIFT;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam logic [VW-1:0] Y_MASK = VW'((1 << SCALE_SHIFT) - 1);

  // Per-pixel sideband that travels alongside the BRAM read.
  typedef struct packed {
    logic        active;
    logic        hs_on;
    logic        vs_on;
    logic        fs;
    logic        fb;
    logic [11:0] pat;
  } side_t;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [VW-1:0]     v_nxt;
  logic              h_last;
  logic              v_last;
  logic              frame_first;
  logic [1:0]        mode_r;
  logic [1:0]        mode_eff;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] pix_addr;
  logic              active;
  logic              fetch;
  logic [2:0]        bar_idx;
  logic [11:0]       pat;
  logic [11:0]       fb_rgb;
  side_t             s0;
  side_t             pipe [RD_LAT+1];
  side_t             tail;
  logic              unused_bits;

  assign h_last      = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last      = (v_cnt == VW'(V_TOTAL - 1));
  assign v_nxt       = v_cnt + VW'(1);
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  // The first pixel of a frame already uses the incoming mode, so a frame
  // never mixes two modes.
  assign mode_eff    = frame_first ? mode : mode_r;
  assign active      = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign fetch       = active && (mode_eff == 2'd0);
  assign pix_addr    = line_base + ADDR_W'(h_cnt >> SCALE_SHIFT);
  assign fb_rgb      = {mem_data[15:12], mem_data[10:7], mem_data[4:1]};
  assign unused_bits = ^{mem_data[11], mem_data[6:5], mem_data[0]};
  assign tail        = pipe[RD_LAT];

  // Raster counters: h wraps at H_TOTAL, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_nxt;
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Line base address: advances by one logical line whenever y changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base <= '0;
    end else if (h_last) begin
      if (v_last) begin
        line_base <= '0;
      end else if ((v_nxt & Y_MASK) == '0) begin
        line_base <= line_base + ADDR_W'(LINE_W);
      end
    end
  end

  // Frame mode register, loaded only at the first pixel of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= 2'd0;
    end else if (frame_first) begin
      mode_r <= mode;
    end
  end

  // Colour bar index: the number of bar boundaries at or left of h_cnt.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= HW'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Test-pattern colour for the current counter position.
  always_comb begin
    pat = 12'h000;
    case (mode_eff)
      2'd1: begin
        case (bar_idx)
          3'd0:    pat = 12'hFFF;
          3'd1:    pat = 12'hFF0;
          3'd2:    pat = 12'h0FF;
          3'd3:    pat = 12'h0F0;
          3'd4:    pat = 12'hF0F;
          3'd5:    pat = 12'hF00;
          3'd6:    pat = 12'h00F;
          default: pat = 12'h000;
        endcase
      end
      2'd2:    pat = ((h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)) ? 12'hFFF : bg_color;
      2'd3:    pat = bg_color;
      default: pat = 12'h000;
    endcase
  end

  // Sideband for the pixel described by the current counters.
  always_comb begin
    s0        = '0;
    s0.active = active;
    s0.hs_on  = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    s0.vs_on  = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
    s0.fs     = frame_first;
    s0.fb     = (mode_eff == 2'd0);
    s0.pat    = pat;
  end

  // Read request register. The address holds while no pixel is fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd <= fetch;
      if (fetch) mem_addr <= pix_addr;
    end
  end

  // Sideband delay line. Its tail lines up with mem_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= RD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int k = 1; k <= RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Output register: pixel colour with blanking, and sync at the pin polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb         <= 12'h000;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      rgb         <= !tail.active ? 12'h000 : (tail.fb ? fb_rgb : tail.pat);
      hs          <= tail.hs_on ? HS_POL : ~HS_POL;
      vs          <= tail.vs_on ? VS_POL : ~VS_POL;
      frame_start <= tail.fs;
    end
  end

endmodule

// File: doc/vga_fb_scan.md
Name: vga_fb_scan

Overview:
Parametrised VGA scan engine and framebuffer reader. It is the successor to the fixed 640x480 vga_mem block. It generates HS/VS timing from parameters and fetches RGB565 pixels from a dual-port BRAM read port with configurable read latency. It supports power-of-two pixel replication (scaling) and built-in test-pattern modes. It sits between the BRAM port B and the board VGA pins and runs entirely in the pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, active level of hs (0 = active-low)
VS_POL, 0, active level of vs
SCALE_SHIFT, 0, pixel replication factor 2^SCALE_SHIFT in both axes
ADDR_W, 19, framebuffer address width
RD_LAT, 1, BRAM read latency in cycles (1..4)

Ports:
clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous active-high reset
mode  in  2  0=framebuffer, 1=colour bars, 2=grid, 3=solid bg_color
bg_color  in  12  RGB444 background colour for modes 2/3
mem_addr  out  ADDR_W  framebuffer read address
mem_rd  out  1  read enable, high only for fetched active pixels
mem_data  in  16  RGB565 read data, valid RD_LAT cycles after mem_addr/mem_rd
hs  out  1  horizontal sync
vs  out  1  vertical sync
rgb  out  12  RGB444 pixel {R,G,B}; 0 outside active area
frame_start  out  1  one-cycle pulse coincident with output of pixel (0,0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: h_cnt=0, v_cnt=0, mem_addr=0, mem_rd=0, rgb=0, hs=~HS_POL, vs=~VS_POL, frame_start=0. All pipeline stages are flushed to blank/inactive. The active mode register loads `mode` on the first cycle after reset.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - Active area: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - Sync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for vs on v_cnt.
- Address generation:
  - Logical coordinates: x=h_cnt>>SCALE_SHIFT, y=v_cnt>>SCALE_SHIFT.
  - mem_addr = y*(H_ACTIVE>>SCALE_SHIFT)+x, truncated to ADDR_W.
  - Computed incrementally with a line-base register; no multiplier.
  - Rows sharing the same y reuse the same base.
- Pipeline, for counter state at cycle t:
  - mem_addr/mem_rd registered at t+1.
  - mem_data valid at t+1+RD_LAT.
  - rgb, hs, vs and frame_start registered at t+2+RD_LAT.
  - hs, vs and the active flag are delayed through the same depth, so sync and pixels stay aligned for any RD_LAT.
- mem_rd: high only when mode==0 and the pixel is active. In modes 1-3 mem_rd stays 0 and mem_addr holds its last value.
- Colour conversion in mode 0: R=d[15:12], G=d[10:7], B=d[4:1].
- Mode 1, colour bars:
  - 8 bars of width H_ACTIVE/8, indexed by h_cnt.
  - Colours left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Mode 2, grid: FFF where h_cnt[4:0]==0 or v_cnt[4:0]==0, else bg_color.
- Mode 3: bg_color everywhere in the active area.
- Blanking: rgb=0 whenever the delayed active flag is 0, regardless of mode.
- Mode latching: `mode` is sampled only when h_cnt==0 and v_cnt==0, so a change mid-frame takes effect at the next frame with no tearing. bg_color is used live.
- Reset mid-operation: counters return to (0,0) on the next edge and the pipeline is flushed. No stale rgb or mem_rd appears after rst falls. The first frame_start comes 2+RD_LAT cycles after the first non-reset cycle.

Test Plan:
- Reset: hold rst for 5 cycles at defaults -> rgb=0, hs=vs=1, mem_rd=0, mem_addr=0 throughout. After release, frame_start pulses at cycle 3 (RD_LAT=1).
- Timing, defaults: hs low for exactly 96 of every 800 cycles. vs low for exactly 1600 cycles (2 lines) every 420000 cycles. frame_start period is 420000.
- Scaling, SCALE_SHIFT=1, mode 0:
  - Line 0 addresses are 0,0,1,1,…,319,319.
  - Line 1 repeats 0..319.
  - Line 2 starts at 320.
  - Final active address is 76799.
- Latency, RD_LAT=3, BRAM model returning data=0xF81F for address 0 -> first active rgb=0xF0F appears exactly 5 cycles after h_cnt=v_cnt=0. hs fall stays H_ACTIVE+H_FP cycles after the first pixel.
- Modes:
  - Switch mode 0→1 mid-frame -> mem_rd stays active until the frame ends. The next frame shows bars, with pixel 80 = 0xFF0 and mem_rd=0.
  - Mode 3 with bg_color=0x123 -> all active pixels 0x123, blanking 0.
- Mid-line reset: assert rst at h_cnt=300, v_cnt=100 for 1 cycle -> outputs return to reset values next cycle. Counters restart at (0,0) and pixel stream addresses resume from 0.
